// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: front-panel controller for the digital clock.
//   Debounces the four panel buttons, runs the set-mode state machine that
//   edits time (hour, minute) then alarm (hour, minute), issues a one-cycle
//   load strobe to the timekeeping datapath, and drives the display's
//   edit-field select and blink signals.
// Ports:
//   clk, clr                 clock, asynchronous active-high reset
//   btn_mode/inc/dec/alarm   raw asynchronous buttons
//   cur_hour, cur_minute     current time from datapath (binary hour, BCD minute)
//   time_load                1-cycle strobe: datapath loads load_hour/load_minute
//   load_hour, load_minute   edited time value (binary hour, BCD minute)
//   alarm_hour, alarm_minute stored alarm (binary hour, BCD minute)
//   alarm_en                 alarm armed
//   edit_sel                 state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_AHOUR, 4 SET_AMIN
//   blink                    blank-enable for the edited field, 0 in RUN
module clock_set_ctrl #(
   parameter int unsigned DEB_CYCLES     = 500000,
   parameter int unsigned TIMEOUT_CYCLES = 500000000,
   parameter int unsigned BLINK_HALF     = 12500000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       btn_alarm,
   input  logic [4:0] cur_hour,
   input  logic [7:0] cur_minute,
   output logic       time_load,
   output logic [4:0] load_hour,
   output logic [7:0] load_minute,
   output logic [4:0] alarm_hour,
   output logic [7:0] alarm_minute,
   output logic       alarm_en,
   output logic [2:0] edit_sel,
   output logic       blink
);

   localparam logic [2:0] ST_RUN       = 3'd0;
   localparam logic [2:0] ST_SET_HOUR  = 3'd1;
   localparam logic [2:0] ST_SET_MIN   = 3'd2;
   localparam logic [2:0] ST_SET_AHOUR = 3'd3;
   localparam logic [2:0] ST_SET_AMIN  = 3'd4;

   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_HALF + 1);

   // Button bit positions inside the packed vectors below
   localparam int unsigned B_MODE  = 0;
   localparam int unsigned B_INC   = 1;
   localparam int unsigned B_DEC   = 2;
   localparam int unsigned B_ALARM = 3;

   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    level;
   logic [3:0]    press;
   logic [DW-1:0] deb_cnt [4];

   logic [2:0]    state;
   logic [4:0]    edit_h;
   logic [7:0]    edit_m;
   logic [TW-1:0] to_cnt;
   logic [BW-1:0] blink_cnt;

   logic mode_p;
   logic inc_p;
   logic dec_p;
   logic alarm_p;
   logic any_p;
   logic in_set;
   logic timeout;

   assign raw = {btn_alarm, btn_dec, btn_inc, btn_mode};

   // ------------------------------------------------------------------
   // Synchronizers and debouncers. The press pulse is registered so it
   // is glitch-free and coincides with nothing else in the datapath.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         press <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int unsigned i = 0; i < 4; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
               deb_cnt[i] <= '0;
               level[i]   <= sync2[i];
               press[i]   <= sync2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign mode_p  = press[B_MODE];
   assign inc_p   = press[B_INC];
   assign dec_p   = press[B_DEC];
   assign alarm_p = press[B_ALARM];
   assign any_p   = |press;
   assign in_set  = (state != ST_RUN);
   assign timeout = in_set && !any_p && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // The strobe is formed from the registered mode pulse so that it is high
   // while edit_h/edit_m still hold the edited time; the same edge that ends
   // it reseeds the edit registers with the alarm value.
   assign time_load   = mode_p && (state == ST_SET_MIN);
   assign load_hour   = edit_h;
   assign load_minute = edit_m;
   assign edit_sel    = state;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd0) begin
         r = (v[7:4] == 4'd0) ? 8'h59 : {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Set-mode FSM and edit/alarm registers. Priority: mode press, then
   // timeout, then inc/dec (simultaneous inc+dec cancels).
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state        <= ST_RUN;
         edit_h       <= '0;
         edit_m       <= '0;
         alarm_hour   <= '0;
         alarm_minute <= '0;
         alarm_en     <= 1'b0;
      end else begin
         if (mode_p) begin
            case (state)
               ST_RUN: begin
                  state  <= ST_SET_HOUR;
                  edit_h <= cur_hour;
                  edit_m <= cur_minute;
               end
               ST_SET_HOUR: state <= ST_SET_MIN;
               ST_SET_MIN: begin
                  state  <= ST_SET_AHOUR;
                  edit_h <= alarm_hour;
                  edit_m <= alarm_minute;
               end
               ST_SET_AHOUR: state <= ST_SET_AMIN;
               ST_SET_AMIN: begin
                  state        <= ST_RUN;
                  alarm_hour   <= edit_h;
                  alarm_minute <= edit_m;
                  alarm_en     <= 1'b1;
               end
               default: state <= ST_RUN;
            endcase
         end else if (timeout) begin
            state <= ST_RUN;
         end else if (in_set && (inc_p != dec_p)) begin
            if (state == ST_SET_HOUR || state == ST_SET_AHOUR) begin
               if (inc_p) begin
                  edit_h <= (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
               end else begin
                  edit_h <= (edit_h == 5'd0) ? 5'd23 : edit_h - 5'd1;
               end
            end else begin
               edit_m <= inc_p ? bcd_inc(edit_m) : bcd_dec(edit_m);
            end
         end

         if (!in_set && alarm_p) begin
            alarm_en <= ~alarm_en;
         end
      end
   end

   // ------------------------------------------------------------------
   // Timeout and blink counters. Both restart on every state entry
   // (mode press or timeout) and are held at zero in RUN.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         to_cnt    <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (!in_set || mode_p || timeout) begin
         to_cnt    <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else begin
         to_cnt <= any_p ? '0 : to_cnt + TW'(1);
         if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: self-checking bench for clock_set_ctrl.
//   Directed panel scenarios followed by randomized button sequences,
//   compared against a behavioural model that keeps minutes as plain
//   integers and applies the panel rules once per completed press.
module tb_clock_set_ctrl;

   localparam int DEB = 4;
   localparam int TMO = 200;
   localparam int BH  = 8;
   localparam int HOLD = DEB + 8;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic       btn_alarm = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [7:0] cur_minute = '0;
   logic       time_load;
   logic [4:0] load_hour;
   logic [7:0] load_minute;
   logic [4:0] alarm_hour;
   logic [7:0] alarm_minute;
   logic       alarm_en;
   logic [2:0] edit_sel;
   logic       blink;

   clock_set_ctrl #(
      .DEB_CYCLES(DEB),
      .TIMEOUT_CYCLES(TMO),
      .BLINK_HALF(BH)
   ) dut (
      .clk(clk),
      .clr(clr),
      .btn_mode(btn_mode),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .btn_alarm(btn_alarm),
      .cur_hour(cur_hour),
      .cur_minute(cur_minute),
      .time_load(time_load),
      .load_hour(load_hour),
      .load_minute(load_minute),
      .alarm_hour(alarm_hour),
      .alarm_minute(alarm_minute),
      .alarm_en(alarm_en),
      .edit_sel(edit_sel),
      .blink(blink)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_AHOUR, 4 SET_AMIN
   int m_state = 0;
   int m_eh = 0;
   int m_em = 0;
   int m_ah = 0;
   int m_am = 0;
   int m_aen = 0;
   int ch = 0;
   int cm = 0;
   int exp_tl = 0;
   int exp_lh = 0;
   int exp_lm = 0;

   // Strobe monitor
   int   tl_seen = 0;
   int   tl_lh = 0;
   int   tl_lm = 0;
   int   tl_consec = 0;
   logic tl_prev = 1'b0;

   always @(negedge clk) begin
      if (time_load === 1'b1) begin
         tl_seen++;
         tl_lh = int'(load_hour);
         tl_lm = int'(load_minute);
         if (tl_prev) tl_consec++;
      end
      tl_prev = (time_load === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int n);
      int v;
      v = ((n / 10) << 4) | (n % 10);
      return v[7:0];
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".sel"}, 32'(edit_sel), m_state);
      check({tag, ".lh"}, 32'(load_hour), m_eh);
      check({tag, ".lm"}, 32'(load_minute), 32'(bcd(m_em)));
      check({tag, ".ah"}, 32'(alarm_hour), m_ah);
      check({tag, ".am"}, 32'(alarm_minute), 32'(bcd(m_am)));
      check({tag, ".aen"}, 32'(alarm_en), m_aen);
      check({tag, ".tlcnt"}, tl_seen, exp_tl);
      check({tag, ".tlh"}, tl_lh, exp_lh);
      check({tag, ".tlm"}, tl_lm, 32'(bcd(exp_lm)));
      if (m_state == 0) check({tag, ".blink"}, 32'(blink), 0);
   endtask

   // mask bits: 1 mode, 2 inc, 4 dec, 8 alarm
   task automatic model_apply(input int mask);
      int pre;
      int d;
      pre = m_state;
      d = ((mask >> 1) & 1) - ((mask >> 2) & 1);
      if ((mask & 1) != 0) begin
         case (m_state)
            0: begin m_state = 1; m_eh = ch; m_em = cm; end
            1: m_state = 2;
            2: begin
               exp_tl++; exp_lh = m_eh; exp_lm = m_em;
               m_state = 3; m_eh = m_ah; m_em = m_am;
            end
            3: m_state = 4;
            default: begin m_ah = m_eh; m_am = m_em; m_aen = 1; m_state = 0; end
         endcase
      end else if (m_state != 0 && d != 0) begin
         if (m_state == 1 || m_state == 3) m_eh = (m_eh + d + 24) % 24;
         else m_em = (m_em + d + 60) % 60;
      end
      if (pre == 0 && (mask & 8) != 0) m_aen = 1 - m_aen;
   endtask

   task automatic set_cur(input int h, input int m);
      ch = h;
      cm = m;
      cur_hour = ch[4:0];
      cur_minute = bcd(cm);
   endtask

   task automatic act(input string tag, input int mask);
      @(posedge clk); #1;
      btn_mode  = (mask & 1) != 0;
      btn_inc   = (mask & 2) != 0;
      btn_dec   = (mask & 4) != 0;
      btn_alarm = (mask & 8) != 0;
      repeat (HOLD) @(posedge clk);
      #1;
      btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_alarm = 0;
      repeat (HOLD) @(posedge clk);
      #1;
      model_apply(mask);
      check_all(tag);
   endtask

   initial begin
      int opts [8] = '{1, 2, 4, 8, 6, 3, 5, 10};
      int tog;
      int last;
      int bad;
      logic pb;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      check("reset.tl", 32'(time_load), 0);
      check("reset.blink", 32'(blink), 0);
      clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Bounce in SET_HOUR with edit_h=5, then blink cadence, then timeout
      set_cur(5, 30);
      act("enter", 1);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         btn_inc = (i % 2) == 0;
         repeat (2) @(posedge clk);
         #1;
      end
      btn_inc = 1;
      repeat (HOLD) @(posedge clk);
      #1;
      btn_inc = 0;
      repeat (HOLD) @(posedge clk);
      #1;
      model_apply(2);
      check_all("bounce");
      check("bounce.h6", 32'(load_hour), 6);

      tog = 0; last = -1; bad = 0; pb = blink;
      for (int i = 0; i < 48; i++) begin
         @(posedge clk); #1;
         if (blink !== pb) begin
            if (last >= 0 && (i - last) != BH) bad++;
            last = i;
            tog++;
         end
         pb = blink;
      end
      check("blink.period", bad, 0);
      check("blink.toggles", 32'(tog >= 5 && tog <= 6), 1);
      check("blink.sel", 32'(edit_sel), 1);

      repeat (TMO) @(posedge clk);
      #1;
      m_state = 0;
      check_all("timeout");
      act("run_inc", 2);

      // Time set with wrap of both fields
      set_cur(23, 59);
      act("ts.m1", 1);
      act("ts.i1", 2);
      act("ts.m2", 1);
      act("ts.i2", 2);
      act("ts.m3", 1);
      act("ts.m4", 1);
      act("ts.m5", 1);

      // Alarm commit and toggle
      act("al.m1", 1);
      act("al.m2", 1);
      act("al.m3", 1);
      act("al.i1", 2);
      act("al.i2", 2);
      act("al.m4", 1);
      act("al.d1", 4);
      act("al.m5", 1);
      check("al.h2", 32'(alarm_hour), 2);
      check("al.m59", 32'(alarm_minute), 32'h59);
      act("al.tog", 8);

      // Minute decrement wraps
      set_cur(7, 0);
      act("dw.m1", 1);
      act("dw.m2", 1);
      act("dw.d1", 4);
      check("dw.59", 32'(load_minute), 32'h59);
      act("dw.d2", 4);
      set_cur(7, 10);
      act("dw.m3", 1);
      act("dw.m4", 1);
      act("dw.m5", 1);
      act("dw.m6", 1);
      act("dw.m7", 1);
      act("dw.d3", 4);
      check("dw.09", 32'(load_minute), 32'h09);

      // Collisions, then reset mid-edit
      act("co.m1", 1);
      act("co.m2", 1);
      act("co.m3", 1);
      act("co.m4", 1);
      act("co.mi", 3);
      act("co.id", 6);
      act("co.m5", 1);
      act("co.m6", 1);
      @(posedge clk); #1;
      clr = 1'b1;
      #2;
      check("clr.async", 32'(edit_sel), 0);
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      m_state = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0; m_aen = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all("clr");

      // Randomized sequences
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
         act("rnd", opts[$urandom_range(0, 7)]);
      end

      check("tl.consec", tl_consec, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
